// File: rtl/i2s_audio_ctrl.sv
// I2S DAC/amplifier sequencer: BCK/WS/DIN from a clk32 enable divider, frames latched at slot-0 boundaries.
// Sample MSB appears in the same frame it is latched; no backpressure, pa_en gated by warmup/drain FSM.
module i2s_audio_ctrl #(
  parameter int BCK_DIV     = 20,
  parameter int WARM_FRAMES = 64
) (
  input  logic        clk32,
  input  logic        por,
  input  logic        enable,
  input  logic        mono,
  input  logic        mute,
  input  logic [15:0] audio_l,
  input  logic [15:0] audio_r,
  output logic        sample_strobe,
  output logic        hp_bck,
  output logic        hp_ws,
  output logic        hp_din,
  output logic        pa_en
);

  localparam int DW = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;
  localparam int FW = $clog2(WARM_FRAMES + 1) + 1;
  localparam logic [DW-1:0] DIV_LAST  = DW'(BCK_DIV - 1);
  localparam logic [FW-1:0] WARM_LAST = FW'(WARM_FRAMES);

  typedef enum logic [1:0] {IDLE, WARMUP, RUN, DRAIN} state_t;

  state_t          state, state_nxt;
  logic [DW-1:0]   div_cnt;
  logic [4:0]      bit_cnt;
  logic [4:0]      slot_nxt;
  logic [31:0]     shreg;
  logic [FW-1:0]   frame_cnt;
  logic            tick, fall, boundary, warm_done, real_load;
  logic [15:0]     mono_s;
  logic [31:0]     load_val;

  assign tick      = (div_cnt == DIV_LAST);
  assign fall      = tick && hp_bck;
  assign boundary  = fall && (bit_cnt == 5'd31);
  assign slot_nxt  = bit_cnt + 5'd1;
  assign warm_done = (frame_cnt == WARM_LAST);

  // floor((L+R)/2) without a 17-bit intermediate; the result always fits in 16 bits
  assign mono_s = {audio_l[15], audio_l[15:1]} + {audio_r[15], audio_r[15:1]}
                + {15'd0, audio_l[0] & audio_r[0]};

  always_comb begin
    load_val = '0;
    if (real_load && !mute)
      load_val = mono ? {mono_s, mono_s} : {audio_l, audio_r};
  end

  always_ff @(posedge clk32 or posedge por) begin
    if (por) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = WARMUP;
      WARMUP:  if (!enable) state_nxt = IDLE;
               else if (boundary && warm_done) state_nxt = RUN;
      RUN:     if (!enable) state_nxt = DRAIN;
      DRAIN:   if (boundary) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pa_en         = (state == RUN);
    real_load     = boundary && ((state == RUN) || ((state == WARMUP) && enable && warm_done));
    sample_strobe = real_load;
  end

  always_ff @(posedge clk32 or posedge por) begin
    if (por) begin
      div_cnt   <= '0;
      hp_bck    <= 1'b0;
      hp_ws     <= 1'b0;
      hp_din    <= 1'b0;
      bit_cnt   <= 5'd31;
      shreg     <= '0;
      frame_cnt <= '0;
    end else if (state_nxt == IDLE) begin
      // Entering or staying in IDLE abandons any partial frame
      div_cnt   <= '0;
      hp_bck    <= 1'b0;
      hp_ws     <= 1'b0;
      hp_din    <= 1'b0;
      bit_cnt   <= 5'd31;
      shreg     <= '0;
      frame_cnt <= '0;
    end else begin
      if (tick) begin
        div_cnt <= '0;
        hp_bck  <= ~hp_bck;
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end
      if (fall) begin
        bit_cnt <= slot_nxt;
        hp_ws   <= (slot_nxt >= 5'd15) && (slot_nxt != 5'd31);
        if (boundary) begin
          shreg  <= load_val;
          hp_din <= load_val[31];
          if (state == WARMUP) frame_cnt <= frame_cnt + FW'(1);
        end else begin
          hp_din <= shreg[5'd31 - slot_nxt];
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_audio_ctrl.sv
// Bench for i2s_audio_ctrl: an I2S receiver rebuilds frames and compares them with words predicted from the driven inputs.
module tb_i2s_audio_ctrl;

  logic        clk32 = 1'b0;
  logic        por = 1'b1;
  logic        enable = 1'b0;
  logic        mono = 1'b0;
  logic        mute = 1'b0;
  logic [15:0] audio_l = '0;
  logic [15:0] audio_r = '0;
  logic        sample_strobe, hp_bck, hp_ws, hp_din, pa_en;

  i2s_audio_ctrl #(.BCK_DIV(2), .WARM_FRAMES(2)) dut (
    .clk32(clk32), .por(por), .enable(enable), .mono(mono), .mute(mute),
    .audio_l(audio_l), .audio_r(audio_r), .sample_strobe(sample_strobe),
    .hp_bck(hp_bck), .hp_ws(hp_ws), .hp_din(hp_din), .pa_en(pa_en)
  );

  always #5 clk32 = ~clk32;

  int n_cmp = 0;
  int n_bad = 0;
  int edge_cnt = 0;
  int strobe_cnt = 0;
  int strobe_edge = 0;
  int frames_rx = 0;
  logic pa_at_strobe = 1'b0;
  logic prev_bck = 1'b0, prev_ws = 1'b0;
  logic [31:0] rx_din = '0, rx_ws = '0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Word the DAC should receive for one frame, straight from the channel rules
  function automatic logic [31:0] model_word(input logic [15:0] l, input logic [15:0] r,
                                             input logic mo, input logic mu);
    int li, ri, s;
    if (mu) return 32'd0;
    if (!mo) return {l, r};
    li = int'($signed(l));
    ri = int'($signed(r));
    s  = (li + ri) >>> 1;
    return {s[15:0], s[15:0]};
  endfunction

  always @(posedge clk32) edge_cnt++;

  always @(negedge clk32) begin
    if (por) begin
      prev_bck = 1'b0;
      prev_ws  = 1'b0;
    end else begin
      if (sample_strobe) begin
        strobe_cnt++;
        strobe_edge  = edge_cnt + 1;
        pa_at_strobe = pa_en;
        exp_q.push_back(model_word(audio_l, audio_r, mono, mute));
      end
      if (hp_bck && !prev_bck) begin
        rx_din = {rx_din[30:0], hp_din};
        rx_ws  = {rx_ws[30:0], hp_ws};
        if (!hp_ws && prev_ws) begin
          frames_rx++;
          check("rx_frame_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) check("rx_frame_data", rx_din, exp_q.pop_front());
          check("rx_ws_pattern", rx_ws, 32'h0001_FFFE);
        end
        prev_ws = hp_ws;
      end
      prev_bck = hp_bck;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk32);
    #2;
  endtask

  task automatic wait_strobe(input string tag);
    int c0 = strobe_cnt;
    int n  = 0;
    while (strobe_cnt == c0 && n < 400) begin
      step(1);
      n++;
    end
    check({tag, "_strobe_seen"}, 32'(strobe_cnt != c0), 32'd1);
  endtask

  initial begin
    int rel0, n, s_prev, f0;
    logic any_bck;

    // Reset held with enable high: everything quiet
    enable  = 1'b1;
    audio_l = 16'h1234;
    audio_r = 16'h5678;
    step(5);
    check("reset_outputs", {27'd0, hp_bck, hp_ws, hp_din, pa_en, sample_strobe}, 32'd0);

    // Two zero warmup frames precede the first real sample
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd0);
    por  = 1'b0;
    rel0 = edge_cnt;
    n = 0;
    while (!hp_bck && n < 20) begin step(1); n++; end
    check("first_bck_rise_cycles", n, 2);
    while (hp_bck && n < 20) begin step(1); n++; end
    check("first_bck_fall_cycles", n, 4);
    check("warmup_pa_en", 32'(pa_en), 32'd0);

    wait_strobe("warm_exit");
    check("first_strobe_edge", strobe_edge - rel0, 260);
    check("pa_en_at_strobe", 32'(pa_at_strobe), 32'd0);
    check("pa_en_after_strobe", 32'(pa_en), 32'd1);
    s_prev = strobe_edge;

    // Stereo, directed then random
    audio_l = 16'h8001;
    audio_r = 16'h00FF;
    wait_strobe("stereo_dir");
    check("frame_period", strobe_edge - s_prev, 128);
    for (int i = 0; i < 4; i++) begin
      audio_l = 16'($urandom);
      audio_r = 16'($urandom);
      wait_strobe("stereo_rand");
    end

    // Mono, directed extremes then random
    mono    = 1'b1;
    audio_l = 16'h7FFF;
    audio_r = 16'h0001;
    wait_strobe("mono_pos");
    audio_l = 16'h8000;
    audio_r = 16'h8000;
    wait_strobe("mono_neg");
    for (int i = 0; i < 3; i++) begin
      audio_l = 16'($urandom);
      audio_r = 16'($urandom);
      wait_strobe("mono_rand");
    end

    // Mute raised mid-frame leaves the frame in flight untouched
    mono    = 1'b0;
    audio_l = 16'h1357;
    audio_r = 16'h2468;
    wait_strobe("pre_mute");
    step(30);
    mute = 1'b1;
    wait_strobe("muted");
    check("mute_pa_en", 32'(pa_en), 32'd1);
    mute    = 1'b0;
    audio_l = 16'($urandom);
    audio_r = 16'($urandom);
    wait_strobe("unmute");

    // Drop enable in slot 10: frame completes, then IDLE
    f0 = frames_rx;
    step(41);
    enable = 1'b0;
    check("pa_en_before_drop", 32'(pa_en), 32'd1);
    step(1);
    check("pa_en_after_drop", 32'(pa_en), 32'd0);
    n = 0;
    while (frames_rx == f0 && n < 200) begin step(1); n++; end
    check("drain_frame_received", frames_rx - f0, 1);
    step(10);
    check("idle_outputs", {28'd0, hp_bck, hp_ws, hp_din, pa_en}, 32'd0);
    check("drain_queue_empty", exp_q.size(), 0);
    any_bck = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step(1);
      any_bck |= hp_bck;
    end
    check("idle_bck_quiet", 32'(any_bck), 32'd0);

    // Restart, then por mid-frame clears outputs at once
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd0);
    enable  = 1'b1;
    audio_l = 16'($urandom);
    audio_r = 16'($urandom);
    wait_strobe("restart");
    n = 0;
    while (!hp_bck && n < 20) begin step(1); n++; end
    check("por_pre_state", {30'd0, pa_en, hp_bck}, 32'd3);
    por = 1'b1;
    #1;
    check("por_async_outputs", {27'd0, hp_bck, hp_ws, hp_din, pa_en, sample_strobe}, 32'd0);
    exp_q.delete();
    step(1);
    por    = 1'b0;
    enable = 1'b0;
    step(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
